// File: rtl/spi_regbank_pkg.sv
// Shared constants for the SPI-facing register bank:
// register map, fast command codes and status byte layout.
package spi_regbank_pkg;

  localparam int unsigned ADDR_CTRL     = 0;
  localparam int unsigned ADDR_IRQ_MASK = 1;
  localparam int unsigned ADDR_IRQ_STAT = 2;
  localparam int unsigned ADDR_SCRATCH  = 3;
  localparam int unsigned ADDR_EVT_CNT  = 4;
  localparam int unsigned ADDR_ID       = 5;
  localparam int unsigned ADDR_GP0      = 6;
  localparam int unsigned ADDR_GP1      = 7;

  localparam logic [5:0] FC_SOFT_RST = 6'h01;
  localparam logic [5:0] FC_IRQ_CLR  = 6'h02;
  localparam logic [5:0] FC_SNAP     = 6'h03;
  localparam logic [5:0] FC_CNT_CLR  = 6'h04;

  localparam int unsigned STAT_IRQ_BIT = 7;
  localparam int unsigned STAT_SAT_BIT = 4;
  localparam int unsigned STAT_EVT_LSB = 0;
  localparam int unsigned STAT_EVT_MSB = 3;

endpackage

// File: rtl/spi_evt_counter.sv
// Saturating 8-bit event counter with a snapshot register.
// Snapshot captures the pre-increment value.
module spi_evt_counter (
  input  logic       clk,
  input  logic       nrst,
  input  logic       evt_i,
  input  logic       snap_i,
  input  logic       clr_i,
  input  logic       srst_i,
  output logic [7:0] snap_o,
  output logic       sat_o
);

  logic [7:0] cnt_q, cnt_d;
  logic [7:0] snap_q, snap_d;

  always_comb begin
    cnt_d  = cnt_q;
    snap_d = snap_q;
    if (srst_i) begin
      cnt_d  = '0;
      snap_d = '0;
    end else begin
      if (snap_i)
        snap_d = cnt_q;
      if (clr_i)
        cnt_d = '0;
      else if (evt_i && cnt_q != 8'hFF)
        cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q  <= '0;
      snap_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      snap_q <= snap_d;
    end
  end

  assign snap_o = snap_q;
  assign sat_o  = (cnt_q == 8'hFF);

endmodule

// File: rtl/spi_regbank.sv
// Register bank behind an SPI slave: RW/W1C/RO registers,
// fast commands, event-driven interrupt status and counter.
module spi_regbank #(
  parameter int          ADDR_W = 3,
  parameter int          REG_W  = 8,
  parameter logic [7:0]  ID_VAL = 8'hA5
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [REG_W-1:0]  reg_wdata,
  input  logic              reg_wr_vld,
  output logic [REG_W-1:0]  reg_rdata,
  output logic [7:0]        status,
  input  logic [5:0]        fastcmd,
  input  logic              fastcmd_vld,
  input  logic [3:0]        events,
  output logic [REG_W-1:0]  ctrl,
  output logic [REG_W-1:0]  gp0,
  output logic [REG_W-1:0]  gp1,
  output logic              irq
);

  import spi_regbank_pkg::*;

  logic [REG_W-1:0] ctrl_q, ctrl_d;
  logic [3:0]       mask_q, mask_d;
  logic [3:0]       stat_q, stat_d;
  logic [REG_W-1:0] scratch_q, scratch_d;
  logic [REG_W-1:0] gp0_q, gp0_d;
  logic [REG_W-1:0] gp1_q, gp1_d;
  logic [REG_W-1:0] rdata_q, rdata_d;
  logic [7:0]       status_q, status_d;
  logic             irq_q, irq_d;

  logic       fc_srst, fc_iclr, fc_snap, fc_cclr;
  logic [3:0] clr_mask;
  logic [7:0] evt_snap;
  logic       sat;

  assign fc_srst = fastcmd_vld && (fastcmd == FC_SOFT_RST);
  assign fc_iclr = fastcmd_vld && (fastcmd == FC_IRQ_CLR);
  assign fc_snap = fastcmd_vld && (fastcmd == FC_SNAP);
  assign fc_cclr = fastcmd_vld && (fastcmd == FC_CNT_CLR);

  function automatic logic hit(input logic [ADDR_W-1:0] a,
                               input int unsigned       r);
    return a == ADDR_W'(r);
  endfunction

  spi_evt_counter u_cnt (
    .clk    (clk),
    .nrst   (nrst),
    .evt_i  (events[0]),
    .snap_i (fc_snap),
    .clr_i  (fc_cclr),
    .srst_i (fc_srst),
    .snap_o (evt_snap),
    .sat_o  (sat)
  );

  always_comb begin
    ctrl_d    = ctrl_q;
    mask_d    = mask_q;
    scratch_d = scratch_q;
    gp0_d     = gp0_q;
    gp1_d     = gp1_q;
    stat_d    = stat_q;
    clr_mask  = '0;
    if (reg_wr_vld) begin
      if (hit(reg_addr, ADDR_CTRL))     ctrl_d    = reg_wdata;
      if (hit(reg_addr, ADDR_IRQ_MASK)) mask_d    = reg_wdata[3:0];
      if (hit(reg_addr, ADDR_SCRATCH))  scratch_d = reg_wdata;
      if (hit(reg_addr, ADDR_GP0))      gp0_d     = reg_wdata;
      if (hit(reg_addr, ADDR_GP1))      gp1_d     = reg_wdata;
      if (hit(reg_addr, ADDR_IRQ_STAT)) clr_mask  = reg_wdata[3:0];
    end
    if (fc_iclr)
      clr_mask = 4'hF;
    // event sets override any same-cycle clear, bit by bit
    stat_d = (stat_q & ~clr_mask) | events;
    if (fc_srst) begin
      ctrl_d    = '0;
      mask_d    = '0;
      scratch_d = '0;
      gp0_d     = '0;
      gp1_d     = '0;
      stat_d    = '0;
    end
  end

  always_comb begin
    rdata_d = '0;
    case (reg_addr)
      ADDR_W'(ADDR_CTRL):     rdata_d = ctrl_q;
      ADDR_W'(ADDR_IRQ_MASK): rdata_d = REG_W'(mask_q);
      ADDR_W'(ADDR_IRQ_STAT): rdata_d = REG_W'(stat_q);
      ADDR_W'(ADDR_SCRATCH):  rdata_d = scratch_q;
      ADDR_W'(ADDR_EVT_CNT):  rdata_d = REG_W'(evt_snap);
      ADDR_W'(ADDR_ID):       rdata_d = REG_W'(ID_VAL);
      ADDR_W'(ADDR_GP0):      rdata_d = gp0_q;
      ADDR_W'(ADDR_GP1):      rdata_d = gp1_q;
      default:                rdata_d = '0;
    endcase
  end

  // status carries the same irq value that irq_q takes this edge
  always_comb begin
    irq_d    = |(stat_q & mask_q);
    status_d = '0;
    status_d[STAT_IRQ_BIT] = irq_d;
    status_d[STAT_SAT_BIT] = sat;
    status_d[STAT_EVT_MSB:STAT_EVT_LSB] = stat_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ctrl_q    <= '0;
      mask_q    <= '0;
      stat_q    <= '0;
      scratch_q <= '0;
      gp0_q     <= '0;
      gp1_q     <= '0;
      rdata_q   <= '0;
      status_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      mask_q    <= mask_d;
      stat_q    <= stat_d;
      scratch_q <= scratch_d;
      gp0_q     <= gp0_d;
      gp1_q     <= gp1_d;
      rdata_q   <= rdata_d;
      status_q  <= status_d;
      irq_q     <= irq_d;
    end
  end

  assign reg_rdata = rdata_q;
  assign status    = status_q;
  assign irq       = irq_q;
  assign ctrl      = ctrl_q;
  assign gp0       = gp0_q;
  assign gp1       = gp1_q;

endmodule

// File: tb/tb_spi_regbank.sv
// Directed bench for spi_regbank with hand-computed
// expected values.
module tb_spi_regbank;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [2:0] reg_addr = '0;
  logic [7:0] reg_wdata = '0;
  logic       reg_wr_vld = 1'b0;
  logic [7:0] reg_rdata;
  logic [7:0] status;
  logic [5:0] fastcmd = '0;
  logic       fastcmd_vld = 1'b0;
  logic [3:0] events = '0;
  logic [7:0] ctrl, gp0, gp1;
  logic       irq;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] rd_v;

  spi_regbank dut (
    .clk         (clk),
    .nrst        (nrst),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_wr_vld  (reg_wr_vld),
    .reg_rdata   (reg_rdata),
    .status      (status),
    .fastcmd     (fastcmd),
    .fastcmd_vld (fastcmd_vld),
    .events      (events),
    .ctrl        (ctrl),
    .gp0         (gp0),
    .gp1         (gp1),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic       wr,
                     input logic [2:0] a,
                     input logic [7:0] d,
                     input logic [5:0] fc,
                     input logic       fv,
                     input logic [3:0] ev);
    @(negedge clk);
    reg_wr_vld  = wr;
    reg_addr    = a;
    reg_wdata   = d;
    fastcmd     = fc;
    fastcmd_vld = fv;
    events      = ev;
    @(negedge clk);
    reg_wr_vld  = 1'b0;
    fastcmd_vld = 1'b0;
    events      = '0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cyc(1'b1, a, d, 6'h00, 1'b0, 4'h0);
  endtask

  task automatic fcmd(input logic [5:0] fc);
    cyc(1'b0, reg_addr, 8'h00, fc, 1'b1, 4'h0);
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] v);
    @(negedge clk);
    reg_addr = a;
    @(negedge clk);
    v = reg_rdata;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rdata", reg_rdata, 8'h00);
    chk("rst_status", status, 8'h00);
    chk("rst_irq", irq, 1'b0);
    chk("rst_ctrl", ctrl, 8'h00);
    chk("rst_gp0", gp0, 8'h00);
    chk("rst_gp1", gp1, 8'h00);
    nrst = 1'b1;

    rd(3'd5, rd_v);
    chk("id", rd_v, 8'hA5);
    wr(3'd3, 8'h3C);
    rd(3'd3, rd_v);
    chk("scratch", rd_v, 8'h3C);
    wr(3'd5, 8'h00);
    rd(3'd5, rd_v);
    chk("id_ro", rd_v, 8'hA5);

    wr(3'd1, 8'h04);
    cyc(1'b0, 3'd0, 8'h00, 6'h00, 1'b0, 4'b0100);
    chk("irq_lag", irq, 1'b0);
    @(negedge clk);
    chk("irq_set", irq, 1'b1);
    chk("status_84", status, 8'h84);
    rd(3'd2, rd_v);
    chk("stat_4", rd_v, 8'h04);
    wr(3'd2, 8'h04);
    @(negedge clk);
    chk("irq_clr", irq, 1'b0);
    rd(3'd2, rd_v);
    chk("stat_w1c", rd_v, 8'h00);

    cyc(1'b1, 3'd2, 8'h02, 6'h00, 1'b0, 4'b0010);
    rd(3'd2, rd_v);
    chk("set_beats_w1c", rd_v, 8'h02);
    cyc(1'b0, 3'd2, 8'h00, 6'h02, 1'b1, 4'b1000);
    rd(3'd2, rd_v);
    chk("irqclr_vs_set", rd_v, 8'h08);

    for (int i = 0; i < 300; i++)
      cyc(1'b0, 3'd0, 8'h00, 6'h00, 1'b0, 4'b0001);
    fcmd(6'h03);
    rd(3'd4, rd_v);
    chk("snap_ff", rd_v, 8'hFF);
    chk("sat_on", status[4], 1'b1);
    fcmd(6'h04);
    @(negedge clk);
    chk("sat_off", status[4], 1'b0);
    rd(3'd4, rd_v);
    chk("snap_kept", rd_v, 8'hFF);

    for (int i = 0; i < 5; i++)
      cyc(1'b0, 3'd0, 8'h00, 6'h00, 1'b0, 4'b0001);
    cyc(1'b0, 3'd0, 8'h00, 6'h03, 1'b1, 4'b0001);
    rd(3'd4, rd_v);
    chk("snap_pre", rd_v, 8'h05);
    fcmd(6'h03);
    rd(3'd4, rd_v);
    chk("live_6", rd_v, 8'h06);

    fcmd(6'h3F);
    rd(3'd4, rd_v);
    chk("bad_fc", rd_v, 8'h06);

    wr(3'd0, 8'h11);
    wr(3'd6, 8'h22);
    chk("ctrl_11", ctrl, 8'h11);
    chk("gp0_22", gp0, 8'h22);
    cyc(1'b1, 3'd7, 8'h77, 6'h01, 1'b1, 4'b1111);
    chk("srst_ctrl", ctrl, 8'h00);
    chk("srst_gp0", gp0, 8'h00);
    chk("srst_gp1", gp1, 8'h00);
    rd(3'd2, rd_v);
    chk("srst_stat", rd_v, 8'h00);
    rd(3'd3, rd_v);
    chk("srst_scratch", rd_v, 8'h00);
    rd(3'd4, rd_v);
    chk("srst_evtcnt", rd_v, 8'h00);

    wr(3'd0, 8'h5A);
    wr(3'd1, 8'h0F);
    cyc(1'b0, 3'd2, 8'h00, 6'h00, 1'b0, 4'b0001);
    @(negedge clk);
    chk("pre_rst_irq", irq, 1'b1);
    chk("pre_rst_rd", reg_rdata, 8'h01);
    events = 4'b0011;
    reg_wr_vld = 1'b1;
    reg_addr = 3'd7;
    reg_wdata = 8'hEE;
    #2;
    nrst = 1'b0;
    #1;
    chk("arst_ctrl", ctrl, 8'h00);
    chk("arst_gp1", gp1, 8'h00);
    chk("arst_irq", irq, 1'b0);
    chk("arst_status", status, 8'h00);
    chk("arst_rdata", reg_rdata, 8'h00);
    @(negedge clk);
    events = '0;
    reg_wr_vld = 1'b0;
    nrst = 1'b1;
    rd(3'd2, rd_v);
    chk("arst_stat", rd_v, 8'h00);
    rd(3'd7, rd_v);
    chk("arst_gp1_rd", rd_v, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
